// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller.
//   - coin codes as seen on coin_i / change_coin_o
//   - unit values of each coin (1 unit = 5 cents)
//   - controller state encoding
//   - coin_units():      coin code -> credit units
//   - change_coin_for(): largest coin not exceeding the remaining credit
package vend_pkg;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5C   = 2'b01;
   localparam logic [1:0] COIN_10C  = 2'b10;
   localparam logic [1:0] COIN_25C  = 2'b11;

   localparam logic [2:0] UNITS_5C  = 3'd1;
   localparam logic [2:0] UNITS_10C = 3'd2;
   localparam logic [2:0] UNITS_25C = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_VEND   = 2'd2,
      ST_CHANGE = 2'd3
   } vend_state_e;

   function automatic logic [2:0] coin_units(input logic [1:0] coin);
      logic [2:0] units;
      case (coin)
         COIN_5C:  units = UNITS_5C;
         COIN_10C: units = UNITS_10C;
         COIN_25C: units = UNITS_25C;
         default:  units = 3'd0;
      endcase
      return units;
   endfunction

   // Greedy payout: callers only use this while credit is nonzero, so the
   // 5c fallback is always a legal coin.
   function automatic logic [1:0] change_coin_for(input int unsigned credit);
      logic [1:0] coin;
      if (credit >= 32'(UNITS_25C)) begin
         coin = COIN_25C;
      end else if (credit >= 32'(UNITS_10C)) begin
         coin = COIN_10C;
      end else begin
         coin = COIN_5C;
      end
      return coin;
   endfunction

endpackage

// File: rtl/vend_price_table.sv
// Writable per-product price table.
//   clk_i, rst_i   : clock, synchronous active-high reset (all prices -> DEFAULT_PRICE)
//   we_i           : write enable
//   wr_id_i        : product written
//   wr_data_i      : new price in units
//   rd_id_i        : product read (combinational read)
//   rd_price_o     : price of rd_id_i
// A write lands on the clock edge, so a read in the same cycle still sees
// the old price.
module vend_price_table #(
   parameter int NUM_PROD      = 4,
   parameter int CREDIT_W      = 6,
   parameter int DEFAULT_PRICE = 5,
   parameter int ID_W          = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                we_i,
   input  logic [ID_W-1:0]     wr_id_i,
   input  logic [CREDIT_W-1:0] wr_data_i,
   input  logic [ID_W-1:0]     rd_id_i,
   output logic [CREDIT_W-1:0] rd_price_o
);

   logic [CREDIT_W-1:0] price_q [NUM_PROD];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_PROD; i++) begin
            price_q[i] <= CREDIT_W'(DEFAULT_PRICE);
         end
      end else if (we_i) begin
         price_q[wr_id_i] <= wr_data_i;
      end
   end

   assign rd_price_o = price_q[rd_id_i];

endmodule

// File: rtl/vend_controller.sv
// Top-level sequencer for the multi-product vending datapath.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   coin_i             : inserted coin code (00 none, 01 5c, 10 10c, 11 25c)
//   coin_reject_o      : registered pulse, previous cycle's coin not credited
//   sel_valid_i/sel_id_i : selection strobe and product
//   sel_nack_o         : registered pulse, previous cycle's selection refused
//   stock_empty_i      : per-product empty flags
//   cancel_i           : refund request (honoured in CREDIT only)
//   price_we_i/price_id_i/price_data_i : price table write port
//   vend_valid_o/vend_id_o/vend_ack_i  : dispense handshake
//   change_valid_o/change_coin_o       : one payout coin per cycle
//   credit_o           : current credit in units
//   busy_o             : high in VEND or CHANGE
//   state_o            : controller state (debug)
//
// Dispense handshake: vend_valid_o rises the cycle after an honoured
// selection and stays high, with vend_id_o stable, until the first clock
// edge at which vend_ack_i is sampled high; that edge completes the
// transfer and vend_valid_o drops the following cycle. An ack in the very
// first valid cycle is legal.
module vend_controller
   import vend_pkg::*;
#(
   parameter int NUM_PROD      = 4,
   parameter int CREDIT_W      = 6,
   parameter int MAX_CREDIT    = 40,
   parameter int DEFAULT_PRICE = 5,
   parameter int TIMEOUT       = 255,
   localparam int ID_W         = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [1:0]          coin_i,
   output logic                coin_reject_o,
   input  logic                sel_valid_i,
   input  logic [ID_W-1:0]     sel_id_i,
   output logic                sel_nack_o,
   input  logic [NUM_PROD-1:0] stock_empty_i,
   input  logic                cancel_i,
   input  logic                price_we_i,
   input  logic [ID_W-1:0]     price_id_i,
   input  logic [CREDIT_W-1:0] price_data_i,
   output logic                vend_valid_o,
   output logic [ID_W-1:0]     vend_id_o,
   input  logic                vend_ack_i,
   output logic                change_valid_o,
   output logic [1:0]          change_coin_o,
   output logic [CREDIT_W-1:0] credit_o,
   output logic                busy_o,
   output logic [1:0]          state_o
);

   localparam int SUM_W = CREDIT_W + 1;
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   vend_state_e         state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [ID_W-1:0]     vend_id_q, vend_id_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                coin_reject_q, coin_reject_d;
   logic                sel_nack_q, sel_nack_d;

   logic [CREDIT_W-1:0] sel_price;
   logic [2:0]          coin_val;
   logic                coin_present;
   logic [SUM_W-1:0]    coin_sum;
   logic                coin_fits;
   logic                sel_ok;
   logic [1:0]          chg_coin;
   logic [CREDIT_W-1:0] credit_after_chg;
   logic                activity;

   vend_price_table #(
      .NUM_PROD      (NUM_PROD),
      .CREDIT_W      (CREDIT_W),
      .DEFAULT_PRICE (DEFAULT_PRICE),
      .ID_W          (ID_W)
   ) u_price_table (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .we_i       (price_we_i),
      .wr_id_i    (price_id_i),
      .wr_data_i  (price_data_i),
      .rd_id_i    (sel_id_i),
      .rd_price_o (sel_price)
   );

   assign coin_val     = coin_units(coin_i);
   assign coin_present = (coin_i != COIN_NONE);
   // One extra bit so an overflowing sum is caught instead of wrapping.
   assign coin_sum     = {1'b0, credit_q} + SUM_W'(coin_val);
   assign coin_fits    = (coin_sum <= SUM_W'(MAX_CREDIT));
   assign sel_ok       = !stock_empty_i[sel_id_i] && (credit_q >= sel_price);

   assign chg_coin         = change_coin_for(32'(credit_q));
   assign credit_after_chg = credit_q - CREDIT_W'(coin_units(chg_coin));

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      vend_id_d     = vend_id_q;
      tmo_d         = '0;
      coin_reject_d = 1'b0;
      sel_nack_d    = 1'b0;
      activity      = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_CREDIT: begin
            // Priority: cancel > selection > coin. A coin that arrives with
            // an honoured cancel or selection is bounced.
            if ((state_q == ST_CREDIT) && cancel_i) begin
               state_d       = ST_CHANGE;
               coin_reject_d = coin_present;
            end else if (sel_valid_i && sel_ok) begin
               credit_d      = credit_q - sel_price;
               vend_id_d     = sel_id_i;
               state_d       = ST_VEND;
               coin_reject_d = coin_present;
            end else begin
               if (sel_valid_i) begin
                  sel_nack_d = 1'b1;
                  activity   = 1'b1;
               end
               if (coin_present) begin
                  if (coin_fits) begin
                     credit_d = coin_sum[CREDIT_W-1:0];
                     state_d  = ST_CREDIT;
                     activity = 1'b1;
                  end else begin
                     coin_reject_d = 1'b1;
                  end
               end
               // Idle-cycle counter; a bounced coin does not count as activity.
               if ((state_q == ST_CREDIT) && !activity) begin
                  if (tmo_q == TMO_LAST) begin
                     state_d = ST_CHANGE;
                  end else begin
                     tmo_d = tmo_q + 1'b1;
                  end
               end
            end
         end
         ST_VEND: begin
            coin_reject_d = coin_present;
            if (vend_ack_i) begin
               state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
         end
         ST_CHANGE: begin
            coin_reject_d = coin_present;
            credit_d      = credit_after_chg;
            if (credit_after_chg == '0) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         credit_q      <= '0;
         vend_id_q     <= '0;
         tmo_q         <= '0;
         coin_reject_q <= 1'b0;
         sel_nack_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         vend_id_q     <= vend_id_d;
         tmo_q         <= tmo_d;
         coin_reject_q <= coin_reject_d;
         sel_nack_q    <= sel_nack_d;
      end
   end

   assign coin_reject_o  = coin_reject_q;
   assign sel_nack_o     = sel_nack_q;
   assign vend_valid_o   = (state_q == ST_VEND);
   assign vend_id_o      = vend_id_q;
   assign change_valid_o = (state_q == ST_CHANGE);
   assign change_coin_o  = (state_q == ST_CHANGE) ? chg_coin : COIN_NONE;
   assign credit_o       = credit_q;
   assign busy_o         = (state_q == ST_VEND) || (state_q == ST_CHANGE);
   assign state_o        = state_q;

endmodule

// File: tb/tb_vend_controller.sv
module tb_vend_controller;

   localparam int NUM_PROD      = 4;
   localparam int CREDIT_W      = 6;
   localparam int MAX_CREDIT    = 40;
   localparam int DEFAULT_PRICE = 5;
   localparam int TIMEOUT       = 255;

   localparam int M_IDLE   = 0;
   localparam int M_CREDIT = 1;
   localparam int M_VEND   = 2;
   localparam int M_CHANGE = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   logic [1:0]          coin = '0;
   logic                coin_reject;
   logic                sel_valid = 1'b0;
   logic [1:0]          sel_id = '0;
   logic                sel_nack;
   logic [3:0]          stock_empty = '0;
   logic                cancel = 1'b0;
   logic                price_we = 1'b0;
   logic [1:0]          price_id = '0;
   logic [5:0]          price_data = '0;
   logic                vend_valid;
   logic [1:0]          vend_id;
   logic                vend_ack = 1'b0;
   logic                change_valid;
   logic [1:0]          change_coin;
   logic [5:0]          credit;
   logic                busy;
   logic [1:0]          state_dbg;

   vend_controller #(
      .NUM_PROD      (NUM_PROD),
      .CREDIT_W      (CREDIT_W),
      .MAX_CREDIT    (MAX_CREDIT),
      .DEFAULT_PRICE (DEFAULT_PRICE),
      .TIMEOUT       (TIMEOUT)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .coin_i         (coin),
      .coin_reject_o  (coin_reject),
      .sel_valid_i    (sel_valid),
      .sel_id_i       (sel_id),
      .sel_nack_o     (sel_nack),
      .stock_empty_i  (stock_empty),
      .cancel_i       (cancel),
      .price_we_i     (price_we),
      .price_id_i     (price_id),
      .price_data_i   (price_data),
      .vend_valid_o   (vend_valid),
      .vend_id_o      (vend_id),
      .vend_ack_i     (vend_ack),
      .change_valid_o (change_valid),
      .change_coin_o  (change_coin),
      .credit_o       (credit),
      .busy_o         (busy),
      .state_o        (state_dbg)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_mode = M_IDLE;
   int m_credit = 0;
   int m_idle = 0;
   int m_vid = 0;
   int m_price [NUM_PROD] = '{DEFAULT_PRICE, DEFAULT_PRICE, DEFAULT_PRICE, DEFAULT_PRICE};
   bit m_rej = 1'b0;
   bit m_nack = 1'b0;
   logic [1:0] exp_q[$];   // coins still to be paid out, in order

   function automatic int coin_value(input logic [1:0] c);
      case (c)
         2'b01:   return 1;
         2'b10:   return 2;
         2'b11:   return 5;
         default: return 0;
      endcase
   endfunction

   // Refund/change: plan the whole payout up front as a greedy coin list.
   task automatic start_payout();
      int c;
      c = m_credit;
      m_mode = M_CHANGE;
      m_idle = 0;
      exp_q.delete();
      while (c > 0) begin
         if (c >= 5) begin exp_q.push_back(2'b11); c -= 5; end
         else if (c >= 2) begin exp_q.push_back(2'b10); c -= 2; end
         else begin exp_q.push_back(2'b01); c -= 1; end
      end
   endtask

   always @(posedge clk) begin : model
      int old_mode;
      int val;
      bit active;
      if (rst) begin
         m_mode = M_IDLE; m_credit = 0; m_idle = 0; m_vid = 0;
         m_rej = 0; m_nack = 0;
         for (int i = 0; i < NUM_PROD; i++) m_price[i] = DEFAULT_PRICE;
         exp_q.delete();
      end else begin
         m_rej = 0; m_nack = 0;
         val = coin_value(coin);
         old_mode = m_mode;
         if (m_mode == M_VEND) begin
            m_rej = (val != 0);
            if (vend_ack) begin
               if (m_credit > 0) start_payout();
               else m_mode = M_IDLE;
            end
         end else if (m_mode == M_CHANGE) begin
            m_rej = (val != 0);
            m_credit -= coin_value(exp_q.pop_front());
            if (m_credit == 0) m_mode = M_IDLE;
         end else if (m_mode == M_CREDIT && cancel) begin
            m_rej = (val != 0);
            start_payout();
         end else if (sel_valid && !stock_empty[sel_id] && m_credit >= m_price[sel_id]) begin
            m_rej = (val != 0);
            m_credit -= m_price[sel_id];
            m_vid = sel_id;
            m_mode = M_VEND;
         end else begin
            active = 0;
            if (sel_valid) begin m_nack = 1; active = 1; end
            if (val != 0) begin
               if (m_credit + val <= MAX_CREDIT) begin
                  m_credit += val; m_mode = M_CREDIT; active = 1;
               end else begin
                  m_rej = 1;
               end
            end
            if (old_mode == M_CREDIT) begin
               if (active) m_idle = 0;
               else begin
                  m_idle++;
                  if (m_idle == TIMEOUT) start_payout();
               end
            end else begin
               m_idle = 0;
            end
         end
         if (price_we) m_price[price_id] = int'(price_data);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("credit", int'(credit), m_credit);
         chk("busy", int'(busy), int'(m_mode == M_VEND || m_mode == M_CHANGE));
         chk("vend_valid", int'(vend_valid), int'(m_mode == M_VEND));
         if (m_mode == M_VEND) chk("vend_id", int'(vend_id), m_vid);
         chk("change_valid", int'(change_valid), int'(m_mode == M_CHANGE));
         if (m_mode == M_CHANGE && exp_q.size() > 0) chk("change_coin", int'(change_coin), int'(exp_q[0]));
         chk("coin_reject", int'(coin_reject), int'(m_rej));
         chk("sel_nack", int'(sel_nack), int'(m_nack));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic put_coin(input logic [1:0] c);
      coin = c;
      cycle();
      coin = 2'b00;
   endtask

   task automatic select(input logic [1:0] id);
      sel_valid = 1'b1;
      sel_id = id;
      cycle();
      sel_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (busy && n < max_cycles) begin
         cycle();
         n++;
      end
      chk("wait_idle_bound", int'(busy), 0);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      int r;
      cycle();
      chk_en = 1'b1;
      cycle();
      chk("reset_credit", int'(credit), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_vend_valid", int'(vend_valid), 0);
      chk("reset_change_valid", int'(change_valid), 0);
      chk("reset_change_coin", int'(change_coin), 0);
      rst = 1'b0;

      // 25c + 10c, buy product 1 (price 5), ack in second vend cycle
      put_coin(2'b11);
      put_coin(2'b10);
      chk("t1_credit", int'(credit), 7);
      select(2'd1);
      chk("t1_vv1", int'(vend_valid), 1);
      chk("t1_vid", int'(vend_id), 1);
      chk("t1_credit_after", int'(credit), 2);
      cycle();
      chk("t1_vv2", int'(vend_valid), 1);
      vend_ack = 1'b1;
      cycle();
      vend_ack = 1'b0;
      chk("t1_chg_valid", int'(change_valid), 1);
      chk("t1_chg_coin", int'(change_coin), 2);
      cycle();
      chk("t1_idle", int'(busy), 0);
      chk("t1_credit_end", int'(credit), 0);

      // ceiling: 38 + 25c rejected, 38 + 10c accepted
      repeat (7) put_coin(2'b11);
      put_coin(2'b10);
      put_coin(2'b01);
      chk("t2_credit38", int'(credit), 38);
      put_coin(2'b11);
      chk("t2_reject", int'(coin_reject), 1);
      chk("t2_credit_kept", int'(credit), 38);
      put_coin(2'b10);
      chk("t2_no_reject", int'(coin_reject), 0);
      chk("t2_credit40", int'(credit), 40);
      cancel = 1'b1;
      cycle();
      cancel = 1'b0;
      wait_idle(20);

      // refused selections
      put_coin(2'b10);
      put_coin(2'b01);
      select(2'd3);
      chk("t3_nack_price", int'(sel_nack), 1);
      chk("t3_credit3", int'(credit), 3);
      put_coin(2'b11);
      put_coin(2'b11);
      stock_empty = 4'b0100;
      select(2'd2);
      stock_empty = 4'b0000;
      chk("t3_nack_stock", int'(sel_nack), 1);
      chk("t3_credit13", int'(credit), 13);
      cancel = 1'b1;
      coin = 2'b01;
      cycle();
      cancel = 1'b0;
      coin = 2'b00;
      chk("t3_cancel_coin_reject", int'(coin_reject), 1);
      chk("t3_cancel_change", int'(change_valid), 1);
      wait_idle(20);

      // cancel with credit 8 -> 25c, 10c, 5c
      put_coin(2'b11);
      put_coin(2'b10);
      put_coin(2'b01);
      cancel = 1'b1;
      cycle();
      cancel = 1'b0;
      chk("t4_coin1", int'(change_coin), 3);
      chk("t4_credit8", int'(credit), 8);
      cycle();
      chk("t4_coin2", int'(change_coin), 2);
      chk("t4_credit3", int'(credit), 3);
      cycle();
      chk("t4_coin3", int'(change_coin), 1);
      chk("t4_credit1", int'(credit), 1);
      cycle();
      chk("t4_idle", int'(busy), 0);
      chk("t4_credit0", int'(credit), 0);

      // timeout refund of credit 4
      put_coin(2'b10);
      put_coin(2'b10);
      repeat (TIMEOUT - 1) cycle();
      chk("t5_still_credit", int'(busy), 0);
      chk("t5_credit4", int'(credit), 4);
      cycle();
      chk("t5_refund1", int'(change_coin), 2);
      chk("t5_refund1_valid", int'(change_valid), 1);
      cycle();
      chk("t5_refund2", int'(change_coin), 2);
      cycle();
      chk("t5_idle", int'(busy), 0);

      // free product from IDLE
      price_we = 1'b1;
      price_id = 2'd0;
      price_data = 6'd0;
      cycle();
      price_we = 1'b0;
      select(2'd0);
      chk("t5_free_vend", int'(vend_valid), 1);
      chk("t5_free_credit", int'(credit), 0);
      vend_ack = 1'b1;
      cycle();
      vend_ack = 1'b0;
      chk("t5_free_done", int'(busy), 0);

      // reset during CHANGE
      put_coin(2'b11);
      put_coin(2'b11);
      cancel = 1'b1;
      cycle();
      cancel = 1'b0;
      cycle();
      chk("t6_mid_change", int'(change_valid), 1);
      chk("t6_credit5", int'(credit), 5);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("t6_rst_credit", int'(credit), 0);
      chk("t6_rst_change", int'(change_valid), 0);
      chk("t6_rst_busy", int'(busy), 0);
      select(2'd0);
      chk("t6_price_restored_nack", int'(sel_nack), 1);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         r = $urandom_range(0, 9);
         coin = (r < 6) ? 2'b00 : 2'($urandom_range(1, 3));
         sel_valid = ($urandom_range(0, 9) == 0);
         sel_id = 2'($urandom_range(0, 3));
         stock_empty = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         cancel = ($urandom_range(0, 29) == 0);
         price_we = ($urandom_range(0, 29) == 0);
         price_id = 2'($urandom_range(0, 3));
         price_data = 6'($urandom_range(0, 12));
         vend_ack = ($urandom_range(0, 9) < 4);
         cycle();
         if (i % 1000 == 999) begin
            rst = 1'b0; coin = '0; sel_valid = 1'b0; cancel = 1'b0;
            price_we = 1'b0; vend_ack = 1'b1;
            repeat (280) cycle();
         end
      end
      rst = 1'b0; coin = '0; sel_valid = 1'b0; cancel = 1'b0;
      price_we = 1'b0; vend_ack = 1'b0;
      repeat (3) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
